// File: rtl/altitude_pkg.sv
// Shared definitions for the altitude and gimbal processing blocks:
// data width, FSM encodings and saturation limits.
package altitude_pkg;

    localparam int N = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

endpackage

// File: rtl/sat_diff.sv
// Signed difference a - b, scaled by 2^DT_SHIFT and clamped to
// the N-bit signed range.
module sat_diff #(
    parameter int N        = 64,
    parameter int DT_SHIFT = 0
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    localparam int W = N + 1 + DT_SHIFT;
    localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

    logic signed [N:0]   d;
    logic signed [W-1:0] ext;
    logic signed [W-1:0] sh;
    logic [W-N:0]        hi;

    assign d   = $signed({a[N-1], a}) - $signed({b[N-1], b});
    assign ext = W'(d);
    assign sh  = ext <<< DT_SHIFT;
    // Result fits only if every bit above the N-bit sign agrees with it.
    assign hi  = sh[W-1:N-1];

    always_comb begin
        y = sh[N-1:0];
        if (!((&hi) || (~|hi))) begin
            y = sh[W-1] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/numerical_differentiator.sv
// Velocity-to-acceleration differentiator with peak tracking and
// engine burnout detection.
module numerical_differentiator #(
    parameter int N        = altitude_pkg::N,
    parameter int DT_SHIFT = 0,
    parameter int BURN_CNT = 3
) (
    input  logic         CLK,
    input  logic         RESETB,
    input  logic         start,
    input  logic         sample_valid,
    input  logic [N-1:0] sample,
    output logic         sample_ready,
    output logic         accel_valid,
    output logic [N-1:0] accel,
    output logic [N-1:0] peak_accel,
    output logic         burnout,
    output logic [1:0]   state
);

    import altitude_pkg::*;

    localparam int CW = $clog2(BURN_CNT + 1);

    state_t       st_q;
    state_t       st_d;
    logic [N-1:0] prev_q;
    logic         pos_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic [N-1:0] diff;
    logic         xfer;
    logic         run_xfer;
    logic         is_pos;
    logic         cnt_hit;

    sat_diff #(
        .N        (N),
        .DT_SHIFT (DT_SHIFT)
    ) u_sat_diff (
        .a (sample),
        .b (prev_q),
        .y (diff)
    );

    assign xfer     = sample_valid & sample_ready;
    assign run_xfer = xfer & (st_q == RUN);
    assign is_pos   = ~diff[N-1] & (|diff);
    assign cnt_inc  = cnt_q + 1'b1;
    assign cnt_hit  = run_xfer & ~is_pos & pos_q
                    & (cnt_inc == CW'(BURN_CNT));
    assign state    = st_q;

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            IDLE:  if (start) st_d = PRIME;
            PRIME: if (xfer) st_d = RUN;
            RUN:   if (cnt_hit) st_d = DONE;
            DONE:  if (start) st_d = PRIME;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            st_q         <= IDLE;
            sample_ready <= 1'b0;
            accel_valid  <= 1'b0;
            accel        <= '0;
            peak_accel   <= '0;
            burnout      <= 1'b0;
            prev_q       <= '0;
            cnt_q        <= '0;
            pos_q        <= 1'b0;
        end else begin
            st_q         <= st_d;
            sample_ready <= (st_d == PRIME) || (st_d == RUN);
            accel_valid  <= run_xfer;
            if ((st_d == PRIME) && (st_q != PRIME)) begin
                peak_accel <= '0;
                burnout    <= 1'b0;
                pos_q      <= 1'b0;
                cnt_q      <= '0;
            end
            if (xfer) begin
                prev_q <= sample;
            end
            if (run_xfer) begin
                accel <= diff;
                if ($signed(diff) > $signed(peak_accel)) begin
                    peak_accel <= diff;
                end
                // Only a fall after a climb counts toward burnout.
                if (is_pos) begin
                    pos_q <= 1'b1;
                    cnt_q <= '0;
                end else if (pos_q) begin
                    cnt_q <= cnt_inc;
                end
                if (cnt_hit) begin
                    burnout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_numerical_differentiator.sv
// Scoreboard bench: two instances (DT_SHIFT 0 and 2) share stimulus;
// a negedge monitor pops expected results on every accel_valid.
module tb_numerical_differentiator;

    localparam logic [63:0] SMAX = 64'h7fff_ffff_ffff_ffff;
    localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [63:0] acc;
        logic [63:0] pk;
        logic        bo;
        logic [1:0]  st;
    } exp_t;

    logic        CLK;
    logic        RESETB;
    logic        start;
    logic        sample_valid;
    logic [63:0] sample;

    logic        r0, v0, b0;
    logic [63:0] a0, p0;
    logic [1:0]  s0;
    logic        r2, v2, b2;
    logic [63:0] a2, p2;
    logic [1:0]  s2;

    exp_t q0[$];
    exp_t q2[$];
    int   total = 0;
    int   bad   = 0;

    numerical_differentiator #(
        .N(64), .DT_SHIFT(0), .BURN_CNT(3)
    ) u0 (
        .CLK(CLK), .RESETB(RESETB), .start(start),
        .sample_valid(sample_valid), .sample(sample),
        .sample_ready(r0), .accel_valid(v0), .accel(a0),
        .peak_accel(p0), .burnout(b0), .state(s0)
    );

    numerical_differentiator #(
        .N(64), .DT_SHIFT(2), .BURN_CNT(3)
    ) u2 (
        .CLK(CLK), .RESETB(RESETB), .start(start),
        .sample_valid(sample_valid), .sample(sample),
        .sample_ready(r2), .accel_valid(v2), .accel(a2),
        .peak_accel(p2), .burnout(b2), .state(s2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d",
                     nm, $signed(act), $signed(want));
        end
    endtask

    task automatic push(input logic [63:0] ac0, input logic [63:0] pk0,
                        input logic [63:0] ac2, input logic [63:0] pk2,
                        input logic bo, input logic [1:0] st);
        exp_t e;
        e.acc = ac0; e.pk = pk0; e.bo = bo; e.st = st;
        q0.push_back(e);
        e.acc = ac2; e.pk = pk2;
        q2.push_back(e);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (v0) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL u0_pulse: got accel %0d want no pulse",
                         $signed(a0));
            end else begin
                e = q0.pop_front();
                chk("u0_accel", a0, e.acc);
                chk("u0_peak", p0, e.pk);
                chk("u0_burnout", 64'(b0), 64'(e.bo));
                chk("u0_state", 64'(s0), 64'(e.st));
            end
        end
        if (v2) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL u2_pulse: got accel %0d want no pulse",
                         $signed(a2));
            end else begin
                e = q2.pop_front();
                chk("u2_accel", a2, e.acc);
                chk("u2_peak", p2, e.pk);
                chk("u2_burnout", 64'(b2), 64'(e.bo));
                chk("u2_state", 64'(s2), 64'(e.st));
            end
        end
    end

    task automatic send(input logic [63:0] v, input logic st);
        @(negedge CLK);
        sample_valid = 1'b1;
        sample       = v;
        start        = st;
    endtask

    task automatic idle();
        @(negedge CLK);
        sample_valid = 1'b0;
        start        = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && (q0.size() + q2.size()) != 0; i++)
            @(negedge CLK);
        chk("drain", 64'(q0.size() + q2.size()), 64'd0);
    endtask

    task automatic do_start();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(posedge CLK);
        #3 RESETB = 1'b0;
        #1;
        chk({tag, "_state"}, 64'(s0), 64'd0);
        chk({tag, "_ready"}, 64'(r0), 64'd0);
        chk({tag, "_valid"}, 64'(v0), 64'd0);
        chk({tag, "_accel"}, a0, 64'd0);
        chk({tag, "_peak"}, p0, 64'd0);
        chk({tag, "_burnout"}, 64'(b0), 64'd0);
        chk({tag, "_u2accel"}, a2, 64'd0);
        @(negedge CLK);
        RESETB = 1'b1;
    endtask

    initial begin
        RESETB       = 1'b0;
        start        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        #2;
        chk("rst_state", 64'(s0), 64'd0);
        chk("rst_ready", 64'(r0), 64'd0);
        chk("rst_accel", a0, 64'd0);
        chk("rst_peak", p0, 64'd0);
        repeat (2) @(negedge CLK);
        RESETB = 1'b1;

        do_start();
        chk("prime_state", 64'(s0), 64'd1);
        chk("prime_ready", 64'(r0), 64'd1);

        push(64'd9799, 64'd9799, 64'd39196, 64'd39196, 1'b0, 2'd2);
        push(64'd9799, 64'd9799, 64'd39196, 64'd39196, 1'b0, 2'd2);
        send(64'd0, 1'b0);
        send(64'd9799, 1'b0);
        send(64'd19598, 1'b0);
        idle();
        drain();
        chk("ramp_peak", p0, 64'd9799);
        chk("ramp_state", 64'(s0), 64'd2);

        push(-64'sd19098, 64'd9799, -64'sd76392, 64'd39196, 1'b0, 2'd2);
        send(64'd500, 1'b0);
        idle();
        drain();
        do_reset("midrun");
        for (int i = 0; i < 3; i++) send(64'd777, 1'b0);
        chk("ignored_state", 64'(s0), 64'd0);
        chk("ignored_ready", 64'(r0), 64'd0);
        idle();
        do_start();
        push(64'd250, 64'd250, 64'd1000, 64'd1000, 1'b0, 2'd2);
        send(64'd1000, 1'b0);
        send(64'd1250, 1'b0);
        idle();
        drain();

        do_reset("sat");
        do_start();
        push(SMAX, SMAX, SMAX, SMAX, 1'b0, 2'd2);
        push(SMIN, SMAX, SMIN, SMAX, 1'b0, 2'd2);
        send(64'd0, 1'b0);
        send(SMAX, 1'b0);
        send(SMIN, 1'b0);
        idle();
        drain();

        do_reset("burn");
        do_start();
        push(64'd100, 64'd100, 64'd400, 64'd400, 1'b0, 2'd2);
        push(64'd100, 64'd100, 64'd400, 64'd400, 1'b0, 2'd2);
        push(64'd0, 64'd100, 64'd0, 64'd400, 1'b0, 2'd2);
        push(-64'sd50, 64'd100, -64'sd200, 64'd400, 1'b0, 2'd2);
        push(-64'sd50, 64'd100, -64'sd200, 64'd400, 1'b1, 2'd3);
        send(64'd0, 1'b0);
        send(64'd100, 1'b0);
        send(64'd200, 1'b0);
        send(64'd200, 1'b0);
        send(64'd150, 1'b0);
        send(64'd100, 1'b0);
        send(64'd90, 1'b0);
        chk("done_ready", 64'(r0), 64'd0);
        chk("done_state", 64'(s0), 64'd3);
        chk("done_burnout", 64'(b0), 64'd1);
        send(64'd80, 1'b0);
        idle();
        drain();
        do_start();
        chk("restart_state", 64'(s0), 64'd1);
        chk("restart_burnout", 64'(b0), 64'd0);
        chk("restart_peak", p0, 64'd0);
        chk("restart_accel_hold", a0, -64'sd50);

        push(-64'sd100, 64'd0, -64'sd400, 64'd0, 1'b0, 2'd2);
        push(-64'sd100, 64'd0, -64'sd400, 64'd0, 1'b0, 2'd2);
        push(-64'sd100, 64'd0, -64'sd400, 64'd0, 1'b0, 2'd2);
        send(64'd500, 1'b0);
        send(64'd400, 1'b0);
        send(64'd300, 1'b1);
        send(64'd200, 1'b0);
        idle();
        drain();
        chk("fall_burnout", 64'(b0), 64'd0);
        chk("fall_state", 64'(s0), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
